// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 keyboard decoder: synchronises the receiver byte stream,
// strips E0/F0 prefixes, tracks Shift/Caps Lock and queues ASCII in a small FWFT FIFO.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ps2_scancode,
  input  logic       ps2_ready,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       overflow,
  input  logic       clear_overflow,
  output logic       shift_active,
  output logic       caps_lock
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  // Lowercase ASCII for letter make codes, 0 when the code is not a letter.
  function automatic logic [7:0] letter_lc(input logic [7:0] code);
    case (code)
      8'h1C: letter_lc = 8'h61;
      8'h32: letter_lc = 8'h62;
      8'h21: letter_lc = 8'h63;
      8'h23: letter_lc = 8'h64;
      8'h24: letter_lc = 8'h65;
      8'h2B: letter_lc = 8'h66;
      8'h34: letter_lc = 8'h67;
      8'h33: letter_lc = 8'h68;
      8'h43: letter_lc = 8'h69;
      8'h3B: letter_lc = 8'h6A;
      8'h42: letter_lc = 8'h6B;
      8'h4B: letter_lc = 8'h6C;
      8'h3A: letter_lc = 8'h6D;
      8'h31: letter_lc = 8'h6E;
      8'h44: letter_lc = 8'h6F;
      8'h4D: letter_lc = 8'h70;
      8'h15: letter_lc = 8'h71;
      8'h2D: letter_lc = 8'h72;
      8'h1B: letter_lc = 8'h73;
      8'h2C: letter_lc = 8'h74;
      8'h3C: letter_lc = 8'h75;
      8'h2A: letter_lc = 8'h76;
      8'h1D: letter_lc = 8'h77;
      8'h22: letter_lc = 8'h78;
      8'h35: letter_lc = 8'h79;
      8'h1A: letter_lc = 8'h7A;
      default: letter_lc = 8'h00;
    endcase
  endfunction

  // Digits, punctuation and control keys; Caps Lock does not affect these.
  function automatic logic [7:0] symbol_char(input logic [7:0] code, input logic shift);
    case (code)
      8'h45: symbol_char = shift ? 8'h29 : 8'h30;
      8'h16: symbol_char = shift ? 8'h21 : 8'h31;
      8'h1E: symbol_char = shift ? 8'h40 : 8'h32;
      8'h26: symbol_char = shift ? 8'h23 : 8'h33;
      8'h25: symbol_char = shift ? 8'h24 : 8'h34;
      8'h2E: symbol_char = shift ? 8'h25 : 8'h35;
      8'h36: symbol_char = shift ? 8'h5E : 8'h36;
      8'h3D: symbol_char = shift ? 8'h26 : 8'h37;
      8'h3E: symbol_char = shift ? 8'h2A : 8'h38;
      8'h46: symbol_char = shift ? 8'h28 : 8'h39;
      8'h41: symbol_char = shift ? 8'h3C : 8'h2C;
      8'h49: symbol_char = shift ? 8'h3E : 8'h2E;
      8'h4A: symbol_char = shift ? 8'h3F : 8'h2F;
      8'h4E: symbol_char = shift ? 8'h5F : 8'h2D;
      8'h55: symbol_char = shift ? 8'h2B : 8'h3D;
      8'h29: symbol_char = 8'h20;
      8'h5A: symbol_char = 8'h0D;
      8'h66: symbol_char = 8'h08;
      8'h0D: symbol_char = 8'h09;
      8'h76: symbol_char = 8'h1B;
      default: symbol_char = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] ext_char(input logic [7:0] code);
    case (code)
      8'h5A: ext_char = 8'h0D;
      8'h75: ext_char = 8'h11;
      8'h72: ext_char = 8'h12;
      8'h6B: ext_char = 8'h13;
      8'h74: ext_char = 8'h14;
      default: ext_char = 8'h00;
    endcase
  endfunction

  // Byte capture: synchroniser and edge detect idle high so a ready level
  // already present at reset is not mistaken for a fresh byte.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   byte_strobe;
  logic [7:0]             code_reg;
  logic                   code_valid_reg;

  assign byte_strobe = sync_reg[SYNC_STAGES-1] & ~prev_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg       <= '1;
      prev_reg       <= 1'b1;
      code_reg       <= 8'h00;
      code_valid_reg <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[SYNC_STAGES-2:0], ps2_ready};
      prev_reg       <= sync_reg[SYNC_STAGES-1];
      code_valid_reg <= byte_strobe;
      if (byte_strobe) begin
        code_reg <= ps2_scancode;
      end
    end
  end

  // Prefix FSM and modifier tracking
  state_t     state_reg, state_next;
  logic       lshift_reg, lshift_next;
  logic       rshift_reg, rshift_next;
  logic       caps_reg, caps_next;
  logic       caps_held_reg, caps_held_next;
  logic       ev_make, ev_ext_make, ev_break;
  logic       ignored;
  logic [7:0] char_reg, char_next;
  logic       char_valid_reg, char_valid_next;
  logic [7:0] lc;

  assign ignored = (code_reg == 8'hAA) || (code_reg == 8'hFA) || (code_reg == 8'hEE) ||
                   (code_reg == 8'hFE) || (code_reg == 8'h00) || (code_reg == 8'hFF);

  always_comb begin
    state_next  = state_reg;
    ev_make     = 1'b0;
    ev_ext_make = 1'b0;
    ev_break    = 1'b0;
    if (code_valid_reg && !ignored) begin
      case (state_reg)
        ST_IDLE: begin
          if (code_reg == 8'hF0)      state_next = ST_BRK;
          else if (code_reg == 8'hE0) state_next = ST_EXT;
          else                        ev_make = 1'b1;
        end
        ST_EXT: begin
          if (code_reg == 8'hF0)      state_next = ST_EXT_BRK;
          else if (code_reg == 8'hE0) state_next = ST_EXT;
          else begin
            ev_ext_make = 1'b1;
            state_next  = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (code_reg != 8'hE0 && code_reg != 8'hF0) begin
            ev_break   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: begin
          // Extended breaks carry no modifier or character meaning here.
          if (code_reg != 8'hE0 && code_reg != 8'hF0) begin
            state_next = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    lshift_next    = lshift_reg;
    rshift_next    = rshift_reg;
    caps_next      = caps_reg;
    caps_held_next = caps_held_reg;
    if (ev_make) begin
      if (code_reg == 8'h12) lshift_next = 1'b1;
      if (code_reg == 8'h59) rshift_next = 1'b1;
      if (code_reg == 8'h58) begin
        if (!caps_held_reg) caps_next = ~caps_reg;
        caps_held_next = 1'b1;
      end
    end
    if (ev_break) begin
      if (code_reg == 8'h12) lshift_next = 1'b0;
      if (code_reg == 8'h59) rshift_next = 1'b0;
      if (code_reg == 8'h58) caps_held_next = 1'b0;
    end
  end

  // Translation uses the modifier state from before this byte; no mapped
  // character is 0x00, so zero doubles as "no character".
  always_comb begin
    char_next = 8'h00;
    lc        = letter_lc(code_reg);
    if (ev_make) begin
      if (lc != 8'h00) begin
        char_next = ((lshift_reg | rshift_reg) ^ caps_reg) ? (lc - 8'h20) : lc;
      end else begin
        char_next = symbol_char(code_reg, lshift_reg | rshift_reg);
      end
    end else if (ev_ext_make) begin
      char_next = ext_char(code_reg);
    end
    char_valid_next = (char_next != 8'h00);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      lshift_reg     <= 1'b0;
      rshift_reg     <= 1'b0;
      caps_reg       <= 1'b0;
      caps_held_reg  <= 1'b0;
      char_reg       <= 8'h00;
      char_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lshift_reg     <= lshift_next;
      rshift_reg     <= rshift_next;
      caps_reg       <= caps_next;
      caps_held_reg  <= caps_held_next;
      char_reg       <= char_next;
      char_valid_reg <= char_valid_next;
    end
  end

  assign shift_active = lshift_reg | rshift_reg;
  assign caps_lock    = caps_reg;

  // Character FIFO (first-word fall-through)
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        fifo_empty, fifo_full, do_pop, do_push, drop;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop     = rd_en & ~fifo_empty;
  assign do_push    = char_valid_reg & (~fifo_full | do_pop);
  assign drop       = char_valid_reg & fifo_full & ~do_pop;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= char_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow     <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // A drop wins over a simultaneous clear.
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  assign rd_valid = ~fifo_empty;
  assign rd_data  = fifo_empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Consumes the byte stream from the PS/2 receiver, which supplies an 8-bit scancode plus a ready level in the PS2_CLK domain. It synchronises that stream into the system clock domain and decodes scan-code set 2 prefixes (E0 extended, F0 break). It tracks Shift and Caps Lock state, translates make codes to ASCII and buffers the characters in a small first-word-fall-through (FWFT) FIFO, which the CPU I/O port drains.

Parameters:
FIFO_DEPTH, 8, character FIFO entries; power of two, minimum 2
SYNC_STAGES, 2, flops in the ps2_ready synchroniser; minimum 2

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ps2_scancode  in  8  byte from PS/2 receiver; asynchronous to clk, stable while ps2_ready=1
ps2_ready  in  1  receiver byte-complete level; asynchronous to clk
rd_en  in  1  pop strobe from CPU port
rd_data  out  8  ASCII at FIFO head; valid when rd_valid=1
rd_valid  out  1  FIFO non-empty
overflow  out  1  sticky: a character was dropped because the FIFO was full
clear_overflow  in  1  clears overflow
shift_active  out  1  left or right Shift currently held
caps_lock  out  1  Caps Lock toggle state

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO empty, rd_valid=0, rd_data=0x00.
  - overflow=0, shift_active=0, caps_lock=0.
  - FSM in IDLE; any pending prefix is discarded.
  - Synchroniser flops and the edge-detect "previous" flop reset to 1, so a ready level already high at reset produces no byte.
- Byte capture:
  - ps2_ready passes through SYNC_STAGES flops.
  - A 0->1 transition at the synchroniser output raises byte_strobe for exactly one cycle.
  - On byte_strobe, ps2_scancode is registered into code_q. It is stable by then because ps2_ready has been high for at least SYNC_STAGES cycles.
  - One byte is accepted per rising edge; a held-high ready yields a single byte.
- Prefix FSM, advanced only on byte_strobe:
  - IDLE: F0->BRK; E0->EXT; other byte->make(code), stay IDLE.
  - EXT: F0->EXT_BRK; E0->EXT; other byte->ext make(code), then IDLE.
  - BRK: E0/F0->BRK (ignored); other byte->break(code), then IDLE.
  - EXT_BRK: other byte->ext break, then IDLE (no output).
  - Bytes AA, FA, EE, FE, 00 and FF are ignored in every state and leave the state unchanged.
- Modifiers:
  - Make 12 sets lshift, make 59 sets rshift; the matching break clears each; shift_active = lshift | rshift.
  - Make 58 toggles caps_lock only if caps_held=0, then sets caps_held; break 58 clears caps_held. Typematic repeats therefore do not re-toggle.
  - Modifier makes produce no character.
- Translation of non-extended make codes:
  - Letters (1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z): uppercase when shift_active XOR caps_lock, else lowercase.
  - Digits (45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9): when shift_active, the US symbols ) ! @ # $ % ^ & * (.
  - Fixed codes: 29->0x20, 5A->0x0D, 66->0x08, 0D->0x09, 76->0x1B, 41->',' or '<', 49->'.' or '>', 4A->'/' or '?', 4E->'-' or '_', 55->'=' or '+'.
  - Extended make codes: 5A->0x0D, 75->0x11, 72->0x12, 6B->0x13, 74->0x14.
  - Unmapped codes and all break codes produce nothing.
- Latency: the translated character is registered one cycle after byte_strobe and written into the FIFO on the following cycle. rd_valid rises exactly SYNC_STAGES+3 clk edges after the first edge that samples ps2_ready=1.
- FIFO:
  - FWFT: rd_data shows the head entry whenever rd_valid=1.
  - rd_en with rd_valid=1 pops at the clk edge; rd_en while empty is ignored.
  - Push while full and no pop: character dropped, overflow set.
  - Push and pop in the same cycle when full: both performed, no overflow.
  - Push and pop in the same cycle when empty: the push is stored; the pop is ignored.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - If clear_overflow and a drop coincide, overflow ends up 1.

Test Plan:
- Shifted letter: bytes 12, 1C, F0 1C, F0 12 -> exactly one char 0x41; shift_active 1 during the sequence, 0 at the end.
- Caps Lock: 58, 58 (repeat), F0 58, then 1C, F0 1C -> caps_lock=1, char 0x41; then 58, F0 58, 1C -> caps_lock=0, char 0x61.
- Extended codes: E0 75 -> 0x11; E0 F0 75 -> nothing; E0 5A -> 0x0D; E0 70 -> nothing; FSM back in IDLE.
- Overflow: 9 make codes 16, 1E, 26, 25, 2E, 36, 3D, 3E, 46 with no reads -> FIFO holds 0x31..0x38 in order, overflow=1. Push plus pop on the next byte while full -> no drop. Then clear_overflow -> overflow=0.
- Latency and strobe: ps2_ready held high 500 cycles with code 29 -> single 0x20, rd_valid rising SYNC_STAGES+3 edges after first sampled high; rd_en while empty -> no change.
- Reset mid-sequence: send F0, assert rst_n=0 for one cycle, then send 1C -> 0x61 is output (prefix discarded); all outputs read reset values during reset.
